// File: rtl/pc_gen_pkg.sv
// Shared definitions for the program-counter generator: redirect levels and
// default reset/exception vectors.
package pc_gen_pkg;

  localparam int LVL_W = 2;

  // Numeric order is the priority order; comparisons rely on it.
  typedef enum logic [LVL_W-1:0] {
    LVL_NONE = 2'd0,
    LVL_ID   = 2'd1,
    LVL_EX   = 2'd2,
    LVL_EXC  = 2'd3
  } redir_lvl_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0100;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle between the pipeline control (master) and pc_gen (slave).
interface pc_gen_if #(
  parameter int ADDR_W = 32
);
  logic              en;
  logic              fetch_ready;
  logic              exc_req;
  logic              ex_redir;
  logic [ADDR_W-1:0] ex_target;
  logic              id_redir;
  logic [ADDR_W-1:0] id_target;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic              pc_valid;
  logic              flush;
  logic              pend_valid;
  logic              misalign;

  modport master (
    output en, fetch_ready, exc_req, ex_redir, ex_target, id_redir, id_target,
    input  pc, pc_next, pc_valid, flush, pend_valid, misalign
  );

  modport slave (
    input  en, fetch_ready, exc_req, ex_redir, ex_target, id_redir, id_target,
    output pc, pc_next, pc_valid, flush, pend_valid, misalign
  );
endinterface

// File: rtl/pc_redir_pend.sv
// Pending-redirect register: keeps the highest (newest on ties) redirect that
// arrived while the pc was held, until it is consumed or cleared.
module pc_redir_pend
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  redir_lvl_e        in_lvl,
  input  logic [ADDR_W-1:0] in_target,
  output redir_lvl_e        lvl,
  output logic [ADDR_W-1:0] target,
  output logic              valid
);

  redir_lvl_e        lvl_q;
  logic [ADDR_W-1:0] target_q;
  logic              take;

  assign take = load && !clr && (in_lvl >= lvl_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n)    lvl_q <= LVL_NONE;
    else if (clr)  lvl_q <= LVL_NONE;
    else if (take) lvl_q <= in_lvl;
  end

  // NOTE: the target is only meaningful while lvl_q != LVL_NONE, so it needs
  // no reset; the level register alone qualifies it.
  always_ff @(posedge clk) begin
    if (take) target_q <= in_target;
  end

  assign lvl    = lvl_q;
  assign target = target_q;
  assign valid  = (lvl_q != LVL_NONE);

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: sequential fetch, prioritised redirects and a
// pending-redirect latch so redirects survive stalls.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(DEF_EXC_VEC),
  parameter int                INC        = 4,
  parameter int                ALIGN_BITS = 2
) (
  input logic     clk,
  input logic     rst_n,
  pc_gen_if.slave bus
);

  logic [ADDR_W-1:0] pc_q, nxt_pc, in_target, pend_target;
  logic              valid_q, flush_q, nxt_flush, advance;
  logic              pend_load, pend_clr, pend_valid;
  redir_lvl_e        in_lvl, pend_lvl;

  assign advance = bus.en && bus.fetch_ready && valid_q;

  always_comb begin
    in_lvl    = LVL_NONE;
    in_target = bus.id_target;
    if (bus.exc_req) begin
      in_lvl    = LVL_EXC;
      in_target = EXC_VEC;
    end else if (bus.ex_redir) begin
      in_lvl    = LVL_EX;
      in_target = bus.ex_target;
    end else if (bus.id_redir) begin
      in_lvl    = LVL_ID;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    nxt_pc    = pc_q;
    nxt_flush = 1'b0;
    if (bus.exc_req) begin
      nxt_pc    = EXC_VEC;
      nxt_flush = 1'b1;
    end else if (advance) begin
      nxt_flush = 1'b1;
      if (bus.ex_redir)                            nxt_pc = bus.ex_target;
      else if (pend_lvl == LVL_EX)                 nxt_pc = pend_target;
      else if (bus.id_redir)                       nxt_pc = bus.id_target;
      else if (pend_lvl == LVL_ID)                 nxt_pc = pend_target;
      else begin
        nxt_pc    = pc_q + ADDR_W'(INC);
        nxt_flush = 1'b0;
      end
    end
  end

  // Held requests go to the pending latch; any advance or exception consumes it.
  assign pend_load = !bus.exc_req && !advance && (in_lvl != LVL_NONE);
  assign pend_clr  = bus.exc_req || advance;

  pc_redir_pend #(.ADDR_W(ADDR_W)) u_pend (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (pend_clr),
    .load      (pend_load),
    .in_lvl    (in_lvl),
    .in_target (in_target),
    .lvl       (pend_lvl),
    .target    (pend_target),
    .valid     (pend_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= nxt_pc;
      valid_q <= 1'b1;
      flush_q <= nxt_flush;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.pc_next    = rst_n ? nxt_pc : RESET_VEC;
  assign bus.pc_valid   = valid_q;
  assign bus.flush      = flush_q;
  assign bus.pend_valid = pend_valid;
  assign bus.misalign   = |pc_q[ALIGN_BITS-1:0];

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the 5-stage pipeline; successor to the single-register PC.
- Holds the fetch address presented to IF and advances it sequentially when fetch is enabled and accepted.
- Applies prioritised redirects: exception, EX-stage branch/jump, ID-stage jump.
- A redirect that arrives while the PC is held is latched as pending, so no redirect is ever lost during a stall.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- EXC_VEC, 32'h0000_0100, exception handler entry address.
- INC, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of low PC bits that must be zero.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  pipeline enable; 0 means hazard stall.
- fetch_ready  in  1  instruction memory accepts the current pc this cycle.
- exc_req  in  1  exception redirect request to EXC_VEC.
- ex_redir  in  1  EX-stage branch/jump redirect request.
- ex_target  in  ADDR_W  EX redirect target.
- id_redir  in  1  ID-stage jump redirect request.
- id_target  in  ADDR_W  ID redirect target.
- pc  out  ADDR_W  current fetch address (registered).
- pc_next  out  ADDR_W  combinational value pc takes at the next edge.
- pc_valid  out  1  pc is a live fetch request.
- flush  out  1  registered one-cycle pulse: pc was loaded from a redirect, so IF/ID must squash.
- pend_valid  out  1  a latched redirect is waiting.
- misalign  out  1  pc[ALIGN_BITS-1:0] != 0 (combinational from pc).

Behaviour:
- Reset (rst_n=0 at posedge, overrides everything):
  - pc=RESET_VEC, pend_valid=0, pending level=NONE, flush=0.
  - pc_valid=0 for the reset cycle and 1 from the first cycle after rst_n=1.
- advance = en & fetch_ready & pc_valid.
- Request level encoding (shared package): NONE=0, ID=1, EX=2, EXC=3. Incoming level is the highest request asserted this cycle. Target by level:
  - EXC: EXC_VEC.
  - EX: ex_target.
  - ID: id_target.
- Exception is forcing:
  - exc_req=1 loads pc=EXC_VEC at the next edge regardless of en/fetch_ready.
  - Clears the pending register and sets flush=1.
- Otherwise, if advance=1, the next pc is chosen by this priority:
  1. Incoming EX.
  2. Pending EX.
  3. Incoming ID.
  4. Pending ID.
  5. pc+INC (modulo 2^ADDR_W; wrap from all-ones region to low addresses without flag).
- Consuming a redirect (incoming or pending) sets flush=1 next cycle and clears pending. Sequential advance sets flush=0.
- If advance=0 and there is an incoming non-EXC request:
  - pc holds.
  - The request is latched when incoming level >= pending level; it replaces the pending target/level (newer equal-level wins).
  - Lower-level incoming requests are dropped.
  - flush=0.
- Simultaneous incoming ID and EX: EX wins; ID is discarded (it is younger and on the squashed path).
- pc_next is combinationally equal to the value loaded at the next edge (equals pc when holding).
- Misaligned targets are loaded as given; misalign flags them for the IF exception path. pc_gen never masks low bits.
- Width rules: targets are ADDR_W wide; the INC addition is truncated to ADDR_W.
- Latency: redirect to new pc is one clock when advancing; a pending redirect is applied on the first advance cycle.

Decomposition:
- Package pc_gen_pkg: redirect level enum (NONE/ID/EX/EXC), level width constant, default vector constants.
- One sub-module, pc_redir_pend: the pending target/level register with its replace-if->= rule and clear input. pc_gen holds the pc register, priority mux, and flush register.

Test Plan:
- Reset then run, en=1, ready=1, no requests: pc goes 0x0,0x4,0x8,0xC; flush=0; pc_valid=0 only in the reset cycle.
- At pc=0x8 with en=1, assert ex_redir to 0x40: next pc=0x40, flush=1 for exactly one cycle, then 0x44.
- en=0 at pc=0x10, assert id_redir to 0x80, then ex_redir to 0x200 the next cycle, release en two cycles later:
  - pend_valid=1 throughout the hold.
  - On release pc=0x200 (EX replaced ID), flush=1, pend_valid=0.
- fetch_ready=0 with pc=0x20, assert exc_req: pc=0x100 next edge, any pending cleared, flush=1.
- Same cycle id_redir=0x300 and ex_redir=0x404, advancing: pc=0x404, misalign=0; then ex_redir to 0x406: pc=0x406, misalign=1.
- rst_n low while pend_valid=1 and pc=0x500: next edge pc=RESET_VEC, pend_valid=0, flush=0; override RESET_VEC=0xBFC0_0000 and check pc after reset.
